mem_arbiter: RTL and testbench

Arbitrates the single unified `instruction_and_data` memory port between the fetch stage (read-only) and the mem stage (read/write). The mem stage has priority, and a starvation counter guarantees fetch forward progress. Read data returns one cycle after acceptance and is routed back to the requester that issued it. The arbiter sits between the pipeline stages and the memory, replacing their direct wiring to it.

---
 rtl/mem_arb_pkg.sv | 13 +
 rtl/mem_arb_fair_cnt.sv | 29 ++
 rtl/mem_arbiter.sv | 101 ++++++++++
 tb/tb_mem_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the fetch/mem-stage memory port arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_arb_fair_cnt.sv
// Starvation counter: counts mem-stage grants taken while fetch waits and
// flags when fetch must be served next.
module mem_arb_fair_cnt #(
    parameter int MAX_RUN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_RUN);

    logic [3:0] run_cnt_reg;

    assign sat = (run_cnt_reg == MAX_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt_reg <= '0;
        end else if (clr) begin
            run_cnt_reg <= '0;
        end else if (inc && !sat) begin
            run_cnt_reg <= run_cnt_reg + 4'd1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one unified memory port between fetch (read-only) and the mem
// stage (read/write); mem stage has priority, bounded by a starvation counter.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int MAX_DM_RUN = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic              if_valid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_ready,
    output logic              dm_valid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    logic              sat;
    logic              grant_if;
    logic              grant_dm;
    owner_t            rsp_own_reg;
    owner_t            rsp_own_next;
    logic [DATA_W-1:0] if_hold_reg;
    logic [DATA_W-1:0] dm_hold_reg;

    mem_arb_fair_cnt #(
        .MAX_RUN (MAX_DM_RUN)
    ) u_fair_cnt (
        .clk (clk),
        .rst (rst),
        .inc (grant_dm && if_req),
        .clr (grant_if || !if_req),
        .sat (sat)
    );

    // Mem stage wins a collision until fetch has waited MAX_DM_RUN grants.
    always_comb begin
        grant_dm = dm_req && !(if_req && sat);
        grant_if = if_req && !grant_dm;
    end

    assign if_ready = grant_if;
    assign dm_ready = grant_dm;

    always_comb begin
        mem_en    = grant_if || grant_dm;
        mem_we    = grant_dm && dm_we;
        mem_addr  = '0;
        mem_wdata = '0;
        if (grant_dm) begin
            mem_addr  = dm_addr;
            mem_wdata = dm_wdata;
        end else if (grant_if) begin
            mem_addr  = if_addr;
        end
    end

    always_comb begin
        rsp_own_next = OWN_NONE;
        if (grant_if) begin
            rsp_own_next = OWN_IF;
        end else if (grant_dm && !dm_we) begin
            rsp_own_next = OWN_DM;
        end
    end

    assign if_valid = (rsp_own_reg == OWN_IF);
    assign dm_valid = (rsp_own_reg == OWN_DM);
    assign if_rdata = if_valid ? mem_rdata : if_hold_reg;
    assign dm_rdata = dm_valid ? mem_rdata : dm_hold_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_own_reg <= OWN_NONE;
            if_hold_reg <= '0;
            dm_hold_reg <= '0;
        end else begin
            rsp_own_reg <= rsp_own_next;
            if (if_valid) begin
                if_hold_reg <= mem_rdata;
            end
            if (dm_valid) begin
                dm_hold_reg <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter against a behavioural model
// of grant priority, starvation limit and one-cycle routed responses.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_ready;
    logic          if_valid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic          dm_we;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic          dm_ready;
    logic          dm_valid;
    logic [DW-1:0] dm_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    mem_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .MAX_DM_RUN (MAXR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_ready  (if_ready),
        .if_valid  (if_valid),
        .if_rdata  (if_rdata),
        .dm_req    (dm_req),
        .dm_we     (dm_we),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_ready  (dm_ready),
        .dm_valid  (dm_valid),
        .dm_rdata  (dm_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous single-port RAM seen by the arbiter.
    logic [DW-1:0] ram [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
            else        mem_rdata <= ram[mem_addr[7:0]];
        end
    end

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [DW-1:0] ref_mem [0:255];
    int            waited;
    logic          e_ifv, e_dmv;
    logic [DW-1:0] e_if_rd, e_dm_rd, if_hold, dm_hold;
    logic          m_gif, m_gdm;
    logic          obs_dmr;
    bit            counting = 0;
    int            cnt_ifv, cnt_dmv;
    logic [9:0]    obs_seq, exp_seq;
    logic [31:0]   v;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        waited  = 0;
        e_ifv   = 1'b0;
        e_dmv   = 1'b0;
        e_if_rd = '0;
        e_dm_rd = '0;
        if_hold = '0;
        dm_hold = '0;
    endtask

    task automatic drive(input logic ifr, input logic [7:0] ifa, input logic dmr,
                         input logic we, input logic [7:0] dma, input logic [DW-1:0] wd);
        if_req   = ifr;
        if_addr  = {24'h0, ifa};
        dm_req   = dmr;
        dm_we    = we;
        dm_addr  = {24'h0, dma};
        dm_wdata = wd;
    endtask

    // One clock cycle: check outputs against the model, then advance the model.
    task automatic step(input bit rst_mid);
        logic [AW-1:0] e_addr;
        #1;
        m_gdm  = dm_req && !(if_req && waited >= MAXR);
        m_gif  = if_req && !m_gdm;
        e_addr = m_gdm ? dm_addr : (m_gif ? if_addr : '0);
        chk("if_ready",  if_ready,  m_gif);
        chk("dm_ready",  dm_ready,  m_gdm);
        chk("mem_en",    mem_en,    m_gif || m_gdm);
        chk("mem_we",    mem_we,    m_gdm && dm_we);
        chk("mem_addr",  mem_addr,  e_addr);
        chk("mem_wdata", mem_wdata, m_gdm ? dm_wdata : '0);
        chk("if_valid",  if_valid,  e_ifv);
        chk("if_rdata",  if_rdata,  e_if_rd);
        chk("dm_valid",  dm_valid,  e_dmv);
        chk("dm_rdata",  dm_rdata,  e_dm_rd);
        obs_dmr = dm_ready;
        if (counting) begin
            cnt_ifv += int'(if_valid);
            cnt_dmv += int'(dm_valid);
        end
        $display("cyc=%0d rst=%0b if_req=%0b dm_req=%0b we=%0b grant=%s if_valid=%0b if_rdata=%h dm_valid=%0b dm_rdata=%h",
                 cyc, rst, if_req, dm_req, dm_we, m_gdm ? "D" : (m_gif ? "I" : "-"),
                 if_valid, if_rdata, dm_valid, dm_rdata);
        if (rst_mid) rst = 1'b1;
        if (rst) begin
            model_reset();
        end else begin
            if (e_ifv) if_hold = e_if_rd;
            if (e_dmv) dm_hold = e_dm_rd;
            e_ifv   = m_gif;
            e_if_rd = m_gif ? ref_mem[if_addr[7:0]] : if_hold;
            if (m_gdm && dm_we) ref_mem[dm_addr[7:0]] = dm_wdata;
            e_dmv   = m_gdm && !dm_we;
            e_dm_rd = e_dmv ? ref_mem[dm_addr[7:0]] : dm_hold;
            waited  = (m_gdm && if_req) ? waited + 1 : 0;
        end
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            ram[i]     = v;
            ref_mem[i] = v;
        end
        ram[8'h10]     = 32'hDEADBEEF;
        ref_mem[8'h10] = 32'hDEADBEEF;
        model_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);

        // Reset and idle
        step(0);
        step(0);
        rst = 1'b0;
        step(0);

        // Fetch-only read of 0x10
        drive(1, 8'h10, 0, 0, 0, 0);
        step(0);
        drive(0, 0, 0, 0, 0, 0);
        chk("fetch_valid", if_valid, 1'b1);
        chk("fetch_rdata", if_rdata, 32'hDEADBEEF);
        step(0);
        chk("fetch_hold_valid", if_valid, 1'b0);
        chk("fetch_hold_rdata", if_rdata, 32'hDEADBEEF);

        // Both requesting for 10 cycles: starvation limit pattern
        exp_seq  = 10'b0111101111;
        cnt_ifv  = 0;
        cnt_dmv  = 0;
        counting = 1;
        for (int i = 0; i < 10; i++) begin
            drive(1, 8'h20 + 8'(i), 1, 0, 8'h30 + 8'(i), 32'h0);
            step(0);
            obs_seq[i] = obs_dmr;
        end
        drive(0, 0, 0, 0, 0, 0);
        step(0);
        counting = 0;
        chk("grant_seq", obs_seq, exp_seq);
        chk("dm_valid_count", cnt_dmv, 8);
        chk("if_valid_count", cnt_ifv, 2);

        // Write then read the same address on consecutive cycles
        drive(0, 0, 1, 1, 8'h40, 32'h12345678);
        step(0);
        drive(0, 0, 1, 0, 8'h40, 32'h0);
        step(0);
        drive(0, 0, 0, 0, 0, 0);
        chk("raw_valid", dm_valid, 1'b1);
        chk("raw_rdata", dm_rdata, 32'h12345678);
        step(0);
        chk("raw_hold", dm_rdata, 32'h12345678);

        // Alternating single-port accepts
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) drive(1, 8'($urandom), 0, 0, 0, 0);
            else            drive(0, 0, 1, 0, 8'($urandom), 0);
            step(0);
        end
        drive(0, 0, 0, 0, 0, 0);
        step(0);

        // Random traffic; an ungranted requester holds its request
        for (int n = 0; n < 300; n++) begin
            if (!if_req || m_gif) begin
                if_req  = 1'($urandom_range(0, 1));
                if_addr = {24'h0, 8'($urandom)};
            end
            if (!dm_req || m_gdm) begin
                dm_req   = ($urandom_range(0, 3) != 0);
                dm_we    = 1'($urandom_range(0, 1));
                dm_addr  = {24'h0, 8'($urandom)};
                dm_wdata = $urandom;
            end
            step(0);
        end
        drive(0, 0, 0, 0, 0, 0);
        step(0);

        // Reset right after a mem-stage read accept discards the response
        drive(0, 0, 1, 0, 8'h40, 32'h0);
        step(1);
        drive(0, 0, 0, 0, 0, 0);
        step(0);
        rst = 1'b0;
        step(0);
        chk("rst_dm_valid", dm_valid, 1'b0);
        chk("rst_dm_rdata", dm_rdata, 32'h0);
        step(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
